// File: rtl/bsg_fpu_classify_pipe.sv
// Registered multi-lane IEEE-754 classifier producing RISC-V fclass words per lane,
// with a sticky class-seen summary and a saturating NaN event counter.
module bsg_fpu_classify_pipe #(
   parameter int e_p         = 8,
   parameter int m_p         = 23,
   parameter int lanes_p     = 2,
   parameter int cnt_width_p = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          v_i,
   output logic                          ready_o,
   input  logic [lanes_p*(1+e_p+m_p)-1:0] a_i,
   input  logic [lanes_p-1:0]            lane_v_i,
   output logic                          v_o,
   output logic [lanes_p*32-1:0]         class_o,
   input  logic                          yumi_i,
   input  logic                          clear_i,
   output logic [9:0]                    seen_o,
   output logic [cnt_width_p-1:0]        nan_count_o
);

   localparam int w_lp     = 1 + e_p + m_p;
   localparam int sum_w_lp = cnt_width_p + 2;

   // Handshake: a beat moves in when v_i & ready_o; the held beat leaves when
   // yumi_i (only while v_o). ready_o = ~v_o | yumi_i, so a beat can enter in
   // the same cycle the previous one is taken; v_i never feeds ready_o.
   logic                      accept;
   logic [lanes_p*32-1:0]     class_n;
   logic [9:0]                seen_inc;
   logic [sum_w_lp-1:0]       nan_inc;
   logic [w_lp-1:0]           op;
   logic                      op_sign;
   logic [e_p-1:0]            op_exp;
   logic [m_p-1:0]            op_man;
   logic                      exp_zero, exp_max, man_zero;
   logic                      is_nan;
   logic [9:0]                lane_bits;

   logic [9:0]                seen_base, seen_next;
   logic [cnt_width_p-1:0]    cnt_base, cnt_next;
   logic [sum_w_lp-1:0]       cnt_sum;

   assign ready_o = ~v_o | yumi_i;
   assign accept  = v_i & ready_o;

   always_comb begin
      class_n   = '0;
      seen_inc  = '0;
      nan_inc   = '0;
      op        = '0;
      op_sign   = 1'b0;
      op_exp    = '0;
      op_man    = '0;
      exp_zero  = 1'b0;
      exp_max   = 1'b0;
      man_zero  = 1'b0;
      is_nan    = 1'b0;
      lane_bits = '0;
      for (int k = 0; k < lanes_p; k++) begin
         op        = a_i[k*w_lp +: w_lp];
         op_sign   = op[w_lp-1];
         op_exp    = op[m_p +: e_p];
         op_man    = op[m_p-1:0];
         exp_zero  = (op_exp == '0);
         exp_max   = &op_exp;
         man_zero  = (op_man == '0);
         is_nan    = exp_max & ~man_zero;
         lane_bits = '0;
         if (is_nan) begin
            lane_bits[8] = ~op_man[m_p-1];
            lane_bits[9] =  op_man[m_p-1];
         end else if (exp_max) begin
            lane_bits[0] =  op_sign;
            lane_bits[7] = ~op_sign;
         end else if (exp_zero & man_zero) begin
            lane_bits[3] =  op_sign;
            lane_bits[4] = ~op_sign;
         end else if (exp_zero) begin
            lane_bits[2] =  op_sign;
            lane_bits[5] = ~op_sign;
         end else begin
            lane_bits[1] =  op_sign;
            lane_bits[6] = ~op_sign;
         end
         if (lane_v_i[k]) begin
            class_n[k*32 +: 10] = lane_bits;
            seen_inc            = seen_inc | lane_bits;
            nan_inc             = nan_inc + {{(sum_w_lp-1){1'b0}}, is_nan};
         end
      end
   end

   // Clear takes effect before the accepted beat's contribution is folded in.
   always_comb begin
      seen_base = clear_i ? '0 : seen_o;
      cnt_base  = clear_i ? '0 : nan_count_o;
      seen_next = seen_base;
      cnt_next  = cnt_base;
      cnt_sum   = {2'b00, cnt_base} + nan_inc;
      if (accept) begin
         seen_next = seen_base | seen_inc;
         if (cnt_sum > {2'b00, {cnt_width_p{1'b1}}})
            cnt_next = {cnt_width_p{1'b1}};
         else
            cnt_next = cnt_sum[cnt_width_p-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_o         <= 1'b0;
         class_o     <= '0;
         seen_o      <= '0;
         nan_count_o <= '0;
      end else begin
         if (accept) begin
            v_o     <= 1'b1;
            class_o <= class_n;
         end else if (yumi_i) begin
            v_o     <= 1'b0;
         end
         seen_o      <= seen_next;
         nan_count_o <= cnt_next;
      end
   end

endmodule

// File: tb/tb_bsg_fpu_classify_pipe.sv
// Bench for bsg_fpu_classify_pipe: single-precision instance driven by directed and
// random beats against a field-level reference model, plus a half-precision instance.
module tb_bsg_fpu_classify_pipe;

   // ---------------- clock / reset ----------------
   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // single precision DUT
   logic        rst_n, v_i, ready_o, v_o, yumi_i, clear_i;
   logic [63:0] a_i;
   logic [1:0]  lane_v_i;
   logic [63:0] class_o;
   logic [9:0]  seen_o;
   logic [7:0]  nan_count_o;

   bsg_fpu_classify_pipe #(.e_p(8), .m_p(23), .lanes_p(2), .cnt_width_p(8)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .ready_o(ready_o), .a_i(a_i),
      .lane_v_i(lane_v_i), .v_o(v_o), .class_o(class_o), .yumi_i(yumi_i),
      .clear_i(clear_i), .seen_o(seen_o), .nan_count_o(nan_count_o)
   );

   // half precision DUT
   logic        h_rst_n, h_v_i, h_ready_o, h_v_o, h_yumi_i, h_clear_i;
   logic [31:0] h_a_i;
   logic [1:0]  h_lane_v_i;
   logic [63:0] h_class_o;
   logic [9:0]  h_seen_o;
   logic [7:0]  h_nan_count_o;

   bsg_fpu_classify_pipe #(.e_p(5), .m_p(10), .lanes_p(2), .cnt_width_p(8)) dut_h (
      .clk_i(clk), .reset_n_i(h_rst_n), .v_i(h_v_i), .ready_o(h_ready_o), .a_i(h_a_i),
      .lane_v_i(h_lane_v_i), .v_o(h_v_o), .class_o(h_class_o), .yumi_i(h_yumi_i),
      .clear_i(h_clear_i), .seen_o(h_seen_o), .nan_count_o(h_nan_count_o)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];
   logic        m_v    = 1'b0;
   logic [9:0]  m_seen = '0;
   int          m_cnt  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // fclass word from field values: magnitude rank zero<sub<normal<inf,
   // positive classes count upward from bit 4, negative downward from bit 3.
   function automatic logic [31:0] ref_class(input logic [63:0] x, input int e, input int m);
      logic [63:0] ex, man, emax;
      logic        sgn;
      int          rank, idx;
      emax = (64'd1 << e) - 64'd1;
      ex   = (x >> m) & emax;
      man  = x & ((64'd1 << m) - 64'd1);
      sgn  = x[e+m];
      if (ex == emax && man != 0)
         return man[m-1] ? 32'h200 : 32'h100;
      if (ex == 0) rank = (man == 0) ? 0 : 1;
      else         rank = (ex == emax) ? 3 : 2;
      idx = sgn ? 3 - rank : 4 + rank;
      return 32'd1 << idx;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  ex;
      logic [22:0] man;
      int kind;
      kind = $urandom_range(0, 4);
      man  = 23'($urandom);
      case (kind)
         0: begin ex = 8'h00; man = '0; end
         1: begin ex = 8'h00; if (man == 0) man = 23'd1; end
         2: ex = 8'($urandom_range(1, 254));
         3: begin ex = 8'hFF; man = '0; end
         default: begin ex = 8'hFF; if (man == 0) man = 23'h400000; end
      endcase
      return {1'($urandom), ex, man};
   endfunction

   // ---------------- driver ----------------
   // Called just after a falling edge; leaves inputs idle after the next falling edge.
   task automatic cycle(input logic v, input logic [63:0] a, input logic [1:0] lv,
                        input logic yumi, input logic clr);
      logic        y, rdy, acc;
      logic [63:0] beat;
      int          nn;
      y = yumi & m_v;
      v_i = v; a_i = a; lane_v_i = lv; yumi_i = y; clear_i = clr;
      #1;
      rdy = !m_v || y;
      check("ready", {63'd0, ready_o}, {63'd0, rdy});
      acc  = v && rdy;
      beat = '0;
      nn   = 0;
      for (int k = 0; k < 2; k++) begin
         if (lv[k]) begin
            beat[k*32 +: 32] = ref_class(a[k*32 +: 32], 8, 23);
            if (beat[k*32+8] || beat[k*32+9]) nn++;
         end
      end
      @(posedge clk);
      if (y) void'(exp_q.pop_front());
      if (clr) begin m_seen = '0; m_cnt = 0; end
      if (acc) begin
         exp_q.push_back(beat);
         m_seen = m_seen | beat[9:0] | beat[41:32];
         m_cnt  = (m_cnt + nn > 255) ? 255 : m_cnt + nn;
      end
      m_v = (exp_q.size() != 0);
      @(negedge clk);
      check("v_o", {63'd0, v_o}, {63'd0, m_v});
      if (m_v) check("class_o", class_o, exp_q[0]);
      check("seen_o", {54'd0, seen_o}, {54'd0, m_seen});
      check("nan_count_o", {56'd0, nan_count_o}, 64'(m_cnt));
      v_i = 1'b0; yumi_i = 1'b0; clear_i = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; v_i = 1'b0; a_i = '0; lane_v_i = '0; yumi_i = 1'b0; clear_i = 1'b0;
      h_rst_n = 1'b0; h_v_i = 1'b0; h_a_i = '0; h_lane_v_i = '0; h_yumi_i = 1'b0; h_clear_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_v_o", {63'd0, v_o}, 64'd0);
      check("rst_class_o", class_o, 64'd0);
      check("rst_seen_o", {54'd0, seen_o}, 64'd0);
      check("rst_nan_count", {56'd0, nan_count_o}, 64'd0);
      check("rst_ready_o", {63'd0, ready_o}, 64'd1);
      rst_n = 1'b1; h_rst_n = 1'b1;

      // class values
      cycle(1'b1, {32'h7FC00000, 32'hFF800000}, 2'b11, 1'b0, 1'b0);
      check("tp_lane0_ninf", class_o[31:0], 64'h001);
      check("tp_lane1_qnan", class_o[63:32], 64'h200);
      check("tp_seen", {54'd0, seen_o}, 64'h201);
      check("tp_cnt", {56'd0, nan_count_o}, 64'd1);
      cycle(1'b1, {32'h00000001, 32'h7F800001}, 2'b11, 1'b1, 1'b0);
      check("tp_lane0_snan", class_o[31:0], 64'h100);
      check("tp_lane1_psub", class_o[63:32], 64'h020);
      cycle(1'b1, {32'h3F800000, 32'h80000000}, 2'b11, 1'b1, 1'b0);
      check("tp_lane0_nzero", class_o[31:0], 64'h008);
      check("tp_lane1_pnorm", class_o[63:32], 64'h040);

      // lane mask
      cycle(1'b1, {32'h7FC00000, 32'h3F800000}, 2'b01, 1'b1, 1'b0);
      check("mask_lane1", class_o[63:32], 64'd0);
      check("mask_cnt", {56'd0, nan_count_o}, 64'd2);

      // backpressure, then back-to-back accepts
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, {rand_op(), rand_op()}, 2'b11, 1'b0, 1'b0);
         check("bp_ready", {63'd0, ready_o}, 64'd0);
      end
      cycle(1'b1, {32'h7F800000, 32'hBF800000}, 2'b11, 1'b1, 1'b0);
      check("b2b_lane0", class_o[31:0], 64'h002);
      check("b2b_lane1", class_o[63:32], 64'h080);
      cycle(1'b1, {rand_op(), rand_op()}, 2'b11, 1'b1, 1'b0);

      // saturation
      cycle(1'b0, '0, 2'b00, 1'b1, 1'b1);
      for (int i = 0; i < 130; i++)
         cycle(1'b1, {32'h7FC00001, 32'hFF800005}, 2'b11, 1'b1, 1'b0);
      check("sat_cnt", {56'd0, nan_count_o}, 64'd255);

      // clear collision
      cycle(1'b1, {32'h7FC00000, 32'hFF800000}, 2'b11, 1'b1, 1'b1);
      check("clr_pre_seen", {54'd0, seen_o}, 64'h201);
      cycle(1'b1, {32'hFF800000, 32'h00000000}, 2'b11, 1'b1, 1'b1);
      check("clr_seen", {54'd0, seen_o}, 64'h011);
      check("clr_cnt", {56'd0, nan_count_o}, 64'd0);

      // random traffic
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom), {rand_op(), rand_op()}, 2'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      repeat (2) cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);

      // half precision and asynchronous reset mid-stall
      h_v_i = 1'b1; h_a_i = {16'hFC01, 16'h7C00}; h_lane_v_i = 2'b11; h_yumi_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      h_v_i = 1'b0;
      check("h_lane0_pinf", h_class_o[31:0], {32'd0, ref_class(64'h7C00, 5, 10)});
      check("h_lane0_const", h_class_o[31:0], 64'h080);
      check("h_lane1_snan", h_class_o[63:32], 64'h100);
      check("h_seen", {54'd0, h_seen_o}, 64'h180);
      check("h_cnt", {56'd0, h_nan_count_o}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      check("h_stall_v", {63'd0, h_v_o}, 64'd1);
      check("h_stall_ready", {63'd0, h_ready_o}, 64'd0);
      #2 h_rst_n = 1'b0;
      #1;
      check("h_arst_v_o", {63'd0, h_v_o}, 64'd0);
      check("h_arst_class", h_class_o, 64'd0);
      check("h_arst_seen", {54'd0, h_seen_o}, 64'd0);
      check("h_arst_cnt", {56'd0, h_nan_count_o}, 64'd0);
      check("h_arst_ready", {63'd0, h_ready_o}, 64'd1);
      @(negedge clk);
      h_rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_fpu_classify_pipe.md
# bsg_fpu_classify_pipe

A registered, multi-lane IEEE-754 classifier with a valid/ready handshake, parametrised in exponent and mantissa width. Each accepted beat carries `lanes_p` operands. The block produces one RISC-V `fclass`-encoded 32-bit word per lane one cycle later. It also keeps a sticky class-seen summary and a saturating NaN event counter for FPU exception and debug telemetry. It sits between the FPU operand read stage and integer write-back, and replaces the purely combinational classifier on multi-lane datapaths.

## Interface
- `e_p`, default 8: exponent width.
- `m_p`, default 23: mantissa width.
- `lanes_p`, default 2: operands per beat.
- `cnt_width_p`, default 8: NaN counter width.
- `clk_i` input 1: single clock. All state updates on the rising edge.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `v_i` input 1: input beat valid.
- `ready_o` output 1: block can accept a beat.
- `a_i` input lanes_p*(1+e_p+m_p): operands. Lane k sits at bits [(k+1)*(1+e_p+m_p)-1 : k*(1+e_p+m_p)], laid out {sign, exp, man}.
- `lane_v_i` input lanes_p: per-lane enable, sampled with the beat.
- `v_o` output 1: output beat valid.
- `class_o` output lanes_p*32: per-lane class word. Lane k is at [32k+31:32k].
- `yumi_i` input 1: consumer takes the output beat. Legal only while `v_o`=1.
- `clear_i` input 1: synchronous clear of `seen_o` and `nan_count_o`.
- `seen_o` output 10: sticky OR of every class bit produced since reset or clear.
- `nan_count_o` output cnt_width_p: saturating count of NaN lanes, sNaN and qNaN combined.

## Operation
- Per-lane decode. Let exp_zero = exp all 0, exp_max = exp all 1, man_zero = man all 0.
  - zero = exp_zero & man_zero
  - subnormal = exp_zero & ~man_zero
  - inf = exp_max & man_zero
  - nan = exp_max & ~man_zero
  - sNaN = nan & ~man[m_p-1]; qNaN = nan & man[m_p-1]
  - normal = none of the above
- Class bit assignment, exactly one bit set per enabled lane:
  - 0: -inf; 1: -normal; 2: -subnormal; 3: -zero
  - 4: +zero; 5: +subnormal; 6: +normal; 7: +inf
  - 8: sNaN; 9: qNaN, for either sign
  - Bits 31:10 are always 0.
- Disabled lane (`lane_v_i[k]`=0): class word is 0. The lane does not contribute to `seen_o` or `nan_count_o`.
- Accept occurs when `v_i & ready_o`. On accept, the class words are registered into `class_o` and `v_o` is set.
- `ready_o` = ~`v_o` | `yumi_i`. This gives full throughput: a new beat is accepted in the same cycle the old one is taken.
- `yumi_i` without a new accept clears `v_o`. `class_o` holds its last value; its contents are don't-care while `v_o`=0.
- Telemetry updates on accept only:
  - `seen_o` |= OR over enabled lanes of class bits 9:0.
  - `nan_count_o` += popcount of enabled NaN lanes (0..lanes_p). It saturates at 2^cnt_width_p-1 and never wraps.
- `clear_i` and accept in the same cycle: clear is applied first, then the new beat's contribution. `seen_o` and `nan_count_o` therefore reflect that beat only.
- `clear_i` does not affect `v_o`, `class_o` or the handshake.
- Asynchronous reset, including mid-beat: `v_o`=0, `class_o`=0, `seen_o`=0, `nan_count_o`=0. `ready_o` therefore reads 1. Any beat held in the output register is dropped.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is visible at `class_o` with `v_o`=1 after edge N.
- `ready_o` depends combinationally on `v_o` and `yumi_i` only. There is no path from `v_i` to `ready_o`.
- `seen_o` and `nan_count_o` update at the same edge as the `class_o` load.
- Stalled output (`v_o`=1, `yumi_i`=0): `class_o` is stable. `ready_o`=0, so `v_i` is ignored and telemetry is unchanged.
- Reset deassertion: the first accept is possible at the first rising edge after `reset_n_i` goes high. The implementation synchronises deassertion externally.

## Test plan
- Class values (e_p=8, m_p=23, lanes_p=2, both lanes enabled). Drive lane0=0xFF800000 and lane1=0x7FC00000. Next cycle: lane0 class=0x001, lane1 class=0x200, `seen_o`=0x201, `nan_count_o`=1. Follow with lane0=0x7F800001, lane1=0x00000001, expecting 0x100 and 0x020. Follow with 0x80000000 and 0x3F800000, expecting 0x008 and 0x040.
- Lane mask: `lane_v_i`=2'b01 with lane1=0x7FC00000. Required: lane1 class=0, `nan_count_o` unchanged, `seen_o` bit 9 unchanged.
- Backpressure: hold `yumi_i`=0 for 5 cycles while `v_i`=1 with changing data. Required: `ready_o`=0, `class_o` frozen, counters frozen. Then assert `yumi_i` with `v_i`=1: back-to-back accept, and the next beat appears one cycle later.
- Saturation (cnt_width_p=8): send 130 beats, each with two NaN lanes. Required: `nan_count_o` stops at 255 and never wraps.
- Clear collision: with `seen_o`=0x201, assert `clear_i` in the same cycle as accepting a +zero and a -inf beat. Required: `seen_o`=0x011, `nan_count_o`=0.
- Half precision and reset: with e_p=5, m_p=10, drive 0x7C00, expecting 0x080, and 0xFC01, expecting 0x100. Then pull `reset_n_i` low mid-stall. Required: `v_o`, `class_o`, `seen_o` and `nan_count_o` go to 0 immediately, without waiting for a clock edge.
